alu_pipe: RTL and testbench

Parametrised, pipelined successor to the existing 8-bit combinational ALU. Accepts operand pairs and a 3-bit opcode over a valid/ready handshake, computes a double-width result through a configurable number of register stages, and presents it with a passthrough tag on a valid/ready output. It sits between the stimulus driver and the scoreboard-side consumer, and supports backpressure and one operation per cycle sustained throughput.

---
 rtl/alu_pipe.sv | 139 +++++++++++++
 tb/tb_alu_pipe.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Pipelined double-width ALU with valid/ready handshake and a passthrough tag.
// Optional flags output enabled by defining ALU_PIPE_FLAGS_EN.
module alu_pipe #(
    parameter int unsigned W      = 8,
    parameter int unsigned STAGES = 2,
    parameter int unsigned TAG_W  = 4
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       a_in,
    input  logic [W-1:0]       b_in,
    input  logic [2:0]         op_in,
    input  logic [TAG_W-1:0]   tag_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*W-1:0]     result_out,
    output logic [TAG_W-1:0]   tag_out,
    output logic [15:0]        txn_count
`ifdef ALU_PIPE_FLAGS_EN
    ,
    output logic [2:0]         flags_out
`endif
);

    localparam int unsigned RW  = 2 * W;
    localparam int unsigned SHW = $clog2(RW);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;

    logic                          adv_c;
    logic [RW-1:0]                 a_ext;
    logic [RW-1:0]                 b_ext;
    logic [RW-1:0]                 alu_d;
    logic [STAGES-1:0]             vld_q;
    logic [STAGES-1:0][RW-1:0]     res_q;
    logic [STAGES-1:0][TAG_W-1:0]  tag_q;
    logic [15:0]                   cnt_q;
    logic [15:0]                   cnt_d;

    // Whole pipeline advances together; it only holds when the output is blocked.
    assign adv_c    = !vld_q[STAGES-1] || out_ready;
    assign in_ready = adv_c;

    always_comb begin
        a_ext = RW'(a_in);
        b_ext = RW'(b_in);
        alu_d = '0;
        case (op_in)
            OP_ADD:  alu_d = a_ext + b_ext;
            OP_SUB:  alu_d = a_ext - b_ext;
            OP_MUL:  alu_d = a_ext * b_ext;
            OP_AND:  alu_d = a_ext & b_ext;
            OP_OR:   alu_d = a_ext | b_ext;
            OP_XOR:  alu_d = a_ext ^ b_ext;
            OP_SHL:  alu_d = a_ext << b_in[SHW-1:0];
            default: begin
                alu_d[1] = (a_in > b_in);
                alu_d[0] = (a_in == b_in);
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            vld_q <= '0;
            res_q <= '0;
            tag_q <= '0;
        end else if (adv_c) begin
            vld_q[0] <= in_valid;
            res_q[0] <= alu_d;
            tag_q[0] <= tag_in;
            for (int i = 1; i < int'(STAGES); i++) begin
                vld_q[i] <= vld_q[i-1];
                res_q[i] <= res_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign out_valid  = vld_q[STAGES-1];
    assign result_out = res_q[STAGES-1];
    assign tag_out    = tag_q[STAGES-1];

    always_comb begin
        cnt_d = cnt_q;
        if (out_valid && out_ready) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign txn_count = cnt_q;

`ifdef ALU_PIPE_FLAGS_EN
    logic [2:0]               flg_d;
    logic [STAGES-1:0][2:0]   flg_q;

    // Carry is bit W of the widened sum; borrow is a plain compare.
    always_comb begin
        flg_d    = '0;
        flg_d[0] = (alu_d == '0);
        if (op_in == OP_ADD) begin
            flg_d[1] = alu_d[W];
        end else if (op_in == OP_SUB) begin
            flg_d[1] = (a_in < b_in);
        end
        flg_d[2] = alu_d[RW-1];
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            flg_q <= '0;
        end else if (adv_c) begin
            flg_q[0] <= flg_d;
            for (int i = 1; i < int'(STAGES); i++) begin
                flg_q[i] <= flg_q[i-1];
            end
        end
    end

    assign flags_out = flg_q[STAGES-1];
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed vectors, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_alu_pipe;

    logic        clock;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a_in;
    logic [7:0]  b_in;
    logic [2:0]  op_in;
    logic [3:0]  tag_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result_out;
    logic [3:0]  tag_out;
    logic [15:0] txn_count;

    logic        v16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic [2:0]  op16;
    logic [3:0]  tag16;
    logic        rdy16;
    logic        s1_rdy, s4_rdy, s1_valid, s4_valid;
    logic [31:0] s1_res, s4_res;
    logic [3:0]  s1_tag, s4_tag;
    logic [15:0] s1_cnt, s4_cnt;
`ifdef ALU_PIPE_FLAGS_EN
    logic [2:0]  flags_out, s1_flags, s4_flags;
`endif

    int n_checks = 0;
    int n_errors = 0;

    alu_pipe #(.W(8), .STAGES(2), .TAG_W(4)) u_dut (
        .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .op_in(op_in), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready), .result_out(result_out),
        .tag_out(tag_out), .txn_count(txn_count)
`ifdef ALU_PIPE_FLAGS_EN
        , .flags_out(flags_out)
`endif
    );

    alu_pipe #(.W(16), .STAGES(1), .TAG_W(4)) u_s1 (
        .clock(clock), .resetn(resetn), .in_valid(v16), .in_ready(s1_rdy),
        .a_in(a16), .b_in(b16), .op_in(op16), .tag_in(tag16),
        .out_valid(s1_valid), .out_ready(rdy16), .result_out(s1_res),
        .tag_out(s1_tag), .txn_count(s1_cnt)
`ifdef ALU_PIPE_FLAGS_EN
        , .flags_out(s1_flags)
`endif
    );

    alu_pipe #(.W(16), .STAGES(4), .TAG_W(4)) u_s4 (
        .clock(clock), .resetn(resetn), .in_valid(v16), .in_ready(s4_rdy),
        .a_in(a16), .b_in(b16), .op_in(op16), .tag_in(tag16),
        .out_valid(s4_valid), .out_ready(rdy16), .result_out(s4_res),
        .tag_out(s4_tag), .txn_count(s4_cnt)
`ifdef ALU_PIPE_FLAGS_EN
        , .flags_out(s4_flags)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the ALU rules as plain integer arithmetic, reduced mod 2^16.
    typedef struct packed {
        logic [15:0] res;
        logic [3:0]  tag;
        logic [2:0]  flg;
    } exp_t;

    function automatic exp_t model(input logic [2:0] op, input logic [7:0] a,
                                   input logic [7:0] b, input logic [3:0] tag);
        int unsigned ua = 32'(a);
        int unsigned ub = 32'(b);
        int unsigned r  = 0;
        exp_t e;
        case (op)
            3'd0: r = ua + ub;
            3'd1: r = ua - ub;
            3'd2: r = ua * ub;
            3'd3: r = ua & ub;
            3'd4: r = ua | ub;
            3'd5: r = ua ^ ub;
            3'd6: r = ua << (ub % 16);
            default: r = (ua > ub ? 2 : 0) + (ua == ub ? 1 : 0);
        endcase
        r = r & 32'hFFFF;
        e.res    = 16'(r);
        e.tag    = tag;
        e.flg[0] = (r == 0);
        e.flg[1] = (op == 3'd0) ? (ua + ub > 255) : (op == 3'd1) ? (ua < ub) : 1'b0;
        e.flg[2] = e.res[15];
        return e;
    endfunction

    exp_t        q[$];
    logic [15:0] mdl_cnt = 16'd0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_res;
    logic [3:0]  prev_tag;

    // Scoreboard: accepts and transfers are decided by values stable across the coming edge.
    always @(negedge clock) begin
        if (!resetn) begin
            q.delete();
            mdl_cnt    = 16'd0;
            prev_stall = 1'b0;
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_txn_count", 64'(txn_count), 64'd0);
            chk("rst_in_ready", 64'(in_ready), 64'd1);
        end else begin
            chk("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
            chk("txn_count_model", 64'(txn_count), 64'(mdl_cnt));
            if (prev_stall) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_result", 64'(result_out), 64'(prev_res));
                chk("stall_tag", 64'(tag_out), 64'(prev_tag));
            end
            if (q.size() == 0) begin
                chk("spurious_valid", 64'(out_valid), 64'd0);
            end else if (out_valid && out_ready) begin
                exp_t e;
                e = q.pop_front();
                chk("sb_result", 64'(result_out), 64'(e.res));
                chk("sb_tag", 64'(tag_out), 64'(e.tag));
`ifdef ALU_PIPE_FLAGS_EN
                chk("sb_flags", 64'(flags_out), 64'(e.flg));
`endif
            end
            if (out_valid && out_ready) mdl_cnt = mdl_cnt + 16'd1;
            if (in_valid && in_ready) q.push_back(model(op_in, a_in, b_in, tag_in));
            prev_stall = out_valid && !out_ready;
            prev_res   = result_out;
            prev_tag   = tag_out;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [3:0] t);
        in_valid = v;
        op_in    = op;
        a_in     = a;
        b_in     = b;
        tag_in   = t;
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_result", 64'(result_out), 64'd0);
        chk("reset_tag", 64'(tag_out), 64'd0);
        chk("reset_txn", 64'(txn_count), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b1;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [3:0]  tag;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{3'd1, 8'h03, 8'h05, 4'd1, 16'hFFFE};
        tbl[1] = '{3'd2, 8'hFF, 8'hFF, 4'd2, 16'hFE01};
        tbl[2] = '{3'd3, 8'hF0, 8'h3C, 4'd3, 16'h0030};
        tbl[3] = '{3'd4, 8'hF0, 8'h0F, 4'd4, 16'h00FF};
        tbl[4] = '{3'd5, 8'hAA, 8'hFF, 4'd5, 16'h0055};
        tbl[5] = '{3'd6, 8'h81, 8'h09, 4'd6, 16'h0200};
        tbl[6] = '{3'd7, 8'h07, 8'h07, 4'd7, 16'h0001};

        drive(1'b0, 3'd0, 8'h00, 8'h00, 4'd0);
        v16 = 1'b0; a16 = '0; b16 = '0; op16 = '0; tag16 = '0; rdy16 = 1'b1;
        do_reset();

        // Single ADD with carry into the upper half.
        drive(1'b1, 3'd0, 8'hFF, 8'h01, 4'd3);
        step();
        in_valid = 1'b0;
        chk("single_latency_early", 64'(out_valid), 64'd0);
        step();
        chk("single_valid", 64'(out_valid), 64'd1);
        chk("single_result", 64'(result_out), 64'h0100);
        chk("single_tag", 64'(tag_out), 64'd3);
`ifdef ALU_PIPE_FLAGS_EN
        chk("single_flags", 64'(flags_out), 64'b010);
`endif
        step();
        chk("single_txn", 64'(txn_count), 64'd1);
        chk("single_done", 64'(out_valid), 64'd0);

        // All opcodes back-to-back; results on consecutive cycles.
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].tag);
            step();
            if (i > 0) begin
                chk("tbl_valid", 64'(out_valid), 64'd1);
                chk("tbl_result", 64'(result_out), 64'(tbl[i-1].exp));
                chk("tbl_tag", 64'(tag_out), 64'(tbl[i-1].tag));
            end
        end
        in_valid = 1'b0;
        step();
        chk("tbl_valid", 64'(out_valid), 64'd1);
        chk("tbl_result", 64'(result_out), 64'(tbl[6].exp));
        step();
        chk("tbl_txn", 64'(txn_count), 64'd8);

        // Backpressure: stall three cycles on the first result.
        do_reset();
        drive(1'b1, 3'd0, 8'h10, 8'h20, 4'd5);
        step();
        drive(1'b1, 3'd0, 8'h01, 8'h02, 4'd6);
        step();
        chk("bp_first_valid", 64'(out_valid), 64'd1);
        chk("bp_first_result", 64'(result_out), 64'h0030);
        out_ready = 1'b0;
        drive(1'b1, 3'd0, 8'h03, 8'h04, 4'd7);
        repeat (3) begin
            @(negedge clock);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_hold_result", 64'(result_out), 64'h0030);
            chk("bp_hold_tag", 64'(tag_out), 64'd5);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("bp_r1_result", 64'(result_out), 64'h0003);
        chk("bp_r1_tag", 64'(tag_out), 64'd6);
        drive(1'b1, 3'd0, 8'h05, 8'h06, 4'd8);
        step();
        in_valid = 1'b0;
        chk("bp_r2_result", 64'(result_out), 64'h0007);
        chk("bp_r2_tag", 64'(tag_out), 64'd7);
        step();
        chk("bp_r3_result", 64'(result_out), 64'h000B);
        chk("bp_r3_tag", 64'(tag_out), 64'd8);
        step();
        chk("bp_empty", 64'(out_valid), 64'd0);
        chk("bp_txn", 64'(txn_count), 64'd4);

        // Reset with two operations in flight.
        drive(1'b1, 3'd2, 8'h12, 8'h34, 4'd9);
        step();
        drive(1'b1, 3'd0, 8'h55, 8'h66, 4'd10);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        resetn    = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_txn", 64'(txn_count), 64'd0);
        chk("mid_rst_result", 64'(result_out), 64'd0);
        repeat (2) @(posedge clock);
        #1;
        resetn    = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("mid_rst_no_stale", 64'(out_valid), 64'd0);
        end

        // W=16 MUL through STAGES=1 and STAGES=4 instances.
        chk("sweep_s1_ready", 64'(s1_rdy), 64'd1);
        chk("sweep_s4_ready", 64'(s4_rdy), 64'd1);
        v16 = 1'b1; a16 = 16'hFFFF; b16 = 16'hFFFF; op16 = 3'd2; tag16 = 4'd9;
        step();
        v16 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("sweep_s1_valid", 64'(s1_valid), 64'(k == 0));
            chk("sweep_s4_valid", 64'(s4_valid), 64'(k == 3));
            if (k == 0) begin
                chk("sweep_s1_result", 64'(s1_res), 64'hFFFE0001);
                chk("sweep_s1_tag", 64'(s1_tag), 64'd9);
`ifdef ALU_PIPE_FLAGS_EN
                chk("sweep_s1_flags", 64'(s1_flags), 64'b100);
`endif
            end
            if (k == 3) begin
                chk("sweep_s4_result", 64'(s4_res), 64'hFFFE0001);
                chk("sweep_s4_tag", 64'(s4_tag), 64'd9);
`ifdef ALU_PIPE_FLAGS_EN
                chk("sweep_s4_flags", 64'(s4_flags), 64'b100);
`endif
            end
            step();
        end
        chk("sweep_s1_txn", 64'(s1_cnt), 64'd1);
        chk("sweep_s4_txn", 64'(s4_cnt), 64'd1);

        // Random traffic with random backpressure.
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom % 10) < 7, 3'($urandom), 8'($urandom), 8'($urandom), 4'($urandom));
            out_ready = ($urandom % 10) < 6;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++) step();
        step();
        chk("rand_drained", 64'(q.size()), 64'd0);

        // Counter wrap after 65536 transfers.
        do_reset();
        drive(1'b1, 3'd0, 8'h01, 8'h01, 4'd1);
        for (int i = 0; i < 70000 && txn_count != 16'hFFFF; i++) step();
        chk("wrap_ffff", 64'(txn_count), 64'hFFFF);
        step();
        chk("wrap_zero", 64'(txn_count), 64'h0000);
        in_valid = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
